// File: rtl/button_conditioner.sv
// Push-button input conditioner: 2-FF synchroniser, per-bit debounce, press/release
// edge pulses and a one-shot long-press detector with a held flag.
module button_conditioner #(
    parameter int unsigned N_BTN       = 5,
    parameter int unsigned CLK_HZ      = 50_000_000,
    parameter int unsigned DEBOUNCE_MS = 20,
    parameter int unsigned LONG_MS     = 5000,
    parameter bit          ACTIVE_LOW  = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_long,
    output logic [N_BTN-1:0] btn_held,
    output logic             any_press
);

    localparam int unsigned DB_CYC   = CLK_HZ / 1000 * DEBOUNCE_MS;
    localparam int unsigned LONG_CYC = CLK_HZ / 1000 * LONG_MS;
    localparam int unsigned DB_W     = $clog2(DB_CYC + 1);
    localparam int unsigned LONG_W   = $clog2(LONG_CYC + 1);

    localparam logic [N_BTN-1:0] POL = {N_BTN{ACTIVE_LOW}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        HELD  = 2'd2
    } hold_state_t;

    logic [N_BTN-1:0] sync1;
    logic [N_BTN-1:0] sync2;
    logic [N_BTN-1:0] level_d;
    logic [N_BTN-1:0] rise;

    // Polarity is normalised ahead of the first flop so reset loads "released".
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btn_raw ^ POL;
            sync2 <= sync1;
        end
    end

    assign rise = btn_level & ~level_d;

    // Edge pulses land one cycle after the debounced level changes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_d     <= '0;
            btn_press   <= '0;
            btn_release <= '0;
            any_press   <= 1'b0;
        end else begin
            level_d     <= btn_level;
            btn_press   <= rise;
            btn_release <= ~btn_level & level_d;
            any_press   <= |rise;
        end
    end

    for (genvar i = 0; i < int'(N_BTN); i++) begin : g_bit
        logic [DB_W-1:0]   db_cnt;
        logic              level_q;
        logic [LONG_W-1:0] hold_cnt;
        logic              long_q;
        logic              held_q;
        hold_state_t       state;

        assign btn_level[i] = level_q;
        assign btn_long[i]  = long_q;
        assign btn_held[i]  = held_q;

        // Level toggles only after DB_CYC consecutive disagreeing samples.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                db_cnt  <= '0;
                level_q <= 1'b0;
            end else if (sync2[i] != level_q) begin
                if (db_cnt == DB_W'(DB_CYC - 1)) begin
                    level_q <= ~level_q;
                    db_cnt  <= '0;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end else begin
                db_cnt <= '0;
            end
        end

        // Long-press detector; hold_cnt freezes in HELD so it fires once per press.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state    <= IDLE;
                hold_cnt <= '0;
                long_q   <= 1'b0;
                held_q   <= 1'b0;
            end else begin
                long_q <= 1'b0;
                case (state)
                    IDLE: begin
                        hold_cnt <= '0;
                        held_q   <= 1'b0;
                        if (rise[i]) begin
                            state <= COUNT;
                        end
                    end
                    COUNT: begin
                        if (!level_q) begin
                            state    <= IDLE;
                            hold_cnt <= '0;
                        end else if (hold_cnt == LONG_W'(LONG_CYC - 1)) begin
                            state  <= HELD;
                            long_q <= 1'b1;
                            held_q <= 1'b1;
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                    HELD: begin
                        if (!level_q) begin
                            state    <= IDLE;
                            hold_cnt <= '0;
                            held_q   <= 1'b0;
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        hold_cnt <= '0;
                        held_q   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DB_CYC=4, LONG_CYC=20, active-low inputs.
module tb_button_conditioner;

    localparam int unsigned N = 5;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] btn_raw;
    logic [N-1:0] btn_level;
    logic [N-1:0] btn_press;
    logic [N-1:0] btn_release;
    logic [N-1:0] btn_long;
    logic [N-1:0] btn_held;
    logic         any_press;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    button_conditioner #(
        .N_BTN      (N),
        .CLK_HZ     (1000),
        .DEBOUNCE_MS(4),
        .LONG_MS    (20),
        .ACTIVE_LOW (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .btn_long   (btn_long),
        .btn_held   (btn_held),
        .any_press  (any_press)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input int i,
                             input logic [N-1:0] lv, input logic [N-1:0] pr,
                             input logic [N-1:0] rl, input logic [N-1:0] lg,
                             input logic [N-1:0] hd);
        check($sformatf("%s level @%0d", tag, i),   32'(btn_level),   32'(lv));
        check($sformatf("%s press @%0d", tag, i),   32'(btn_press),   32'(pr));
        check($sformatf("%s release @%0d", tag, i), 32'(btn_release), 32'(rl));
        check($sformatf("%s long @%0d", tag, i),    32'(btn_long),    32'(lg));
        check($sformatf("%s held @%0d", tag, i),    32'(btn_held),    32'(hd));
        check($sformatf("%s any @%0d", tag, i),     32'(any_press),   32'(|pr));
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Raw low for `hold` cycles starting after tick 0; expected event ticks supplied by caller.
    task automatic run_press(input string tag, input logic [N-1:0] mask, input int hold,
                             input int total, input int lvl_on, input int lvl_off,
                             input int press_at, input int rel_at, input int long_at);
        logic [N-1:0] lv, pr, rl, lg, hd;
        btn_raw = ~mask;
        for (int i = 1; i <= total; i++) begin
            tick();
            lv = (i >= lvl_on && i < lvl_off) ? mask : '0;
            pr = (i == press_at) ? mask : '0;
            rl = (i == rel_at) ? mask : '0;
            lg = (long_at != 0 && i == long_at) ? mask : '0;
            hd = (long_at != 0 && i >= long_at && i < rel_at) ? mask : '0;
            check_all(tag, i, lv, pr, rl, lg, hd);
            if (i == hold) btn_raw = '1;
        end
    endtask

    initial begin
        logic [N-1:0] m;
        logic [N-1:0] lv, pr, rl, lg, hd;

        // 1. Reset with buttons idle, then 50 quiet cycles
        rst     = 1'b1;
        btn_raw = '1;
        tick();
        tick();
        check_all("rst_hold", 0, '0, '0, '0, '0, '0);
        rst = 1'b0;
        for (int i = 1; i <= 50; i++) begin
            tick();
            check_all("idle", i, '0, '0, '0, '0, '0);
        end

        // 2. Clean press on bit 2
        run_press("clean", 5'b00100, 15, 28, 6, 21, 7, 22, 0);

        // 3. Bounce on bit 0: low 3, high 1, low 3, high
        btn_raw = 5'b11110;
        for (int i = 1; i <= 14; i++) begin
            tick();
            check($sformatf("bounce level @%0d", i), 32'(btn_level), 32'd0);
            check($sformatf("bounce press @%0d", i), 32'(btn_press), 32'd0);
            if (i == 3) btn_raw = 5'b11111;
            if (i == 4) btn_raw = 5'b11110;
            if (i == 7) btn_raw = 5'b11111;
        end

        // 4. Long press on bit 4
        run_press("long", 5'b10000, 40, 52, 6, 46, 7, 47, 27);

        // 5. Short press on bit 1
        run_press("short", 5'b00010, 12, 24, 6, 18, 7, 19, 0);

        // 6. Simultaneous bits 0 and 3, reset mid-hold, then re-press after reset
        m       = 5'b01001;
        btn_raw = ~m;
        for (int i = 1; i <= 10; i++) begin
            tick();
            lv = (i >= 6) ? m : '0;
            pr = (i == 7) ? m : '0;
            check_all("simul", i, lv, pr, '0, '0, '0);
        end
        rst = 1'b1;
        #1;
        check_all("simul_rst", 0, '0, '0, '0, '0, '0);
        tick();
        check_all("simul_rst", 1, '0, '0, '0, '0, '0);
        tick();
        check_all("simul_rst", 2, '0, '0, '0, '0, '0);
        rst = 1'b0;
        for (int j = 1; j <= 32; j++) begin
            tick();
            lv = (j >= 6) ? m : '0;
            pr = (j == 7) ? m : '0;
            lg = (j == 27) ? m : '0;
            hd = (j >= 27) ? m : '0;
            check_all("repress", j, lv, pr, '0, lg, hd);
        end
        btn_raw = '1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            lv = (k < 6) ? m : '0;
            rl = (k == 7) ? m : '0;
            hd = (k < 7) ? m : '0;
            check_all("unpress", k, lv, '0, rl, '0, hd);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
